// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and the hazard controller.
// The datapath side (master) reports memory readiness, branch resolution and
// register usage. The controller side (slave) returns stage enables, flushes
// and the fetch redirect.
interface pipeline_hazard_ctrl_if;
  // Datapath status
  logic        imem_busywait;
  logic        dmem_busywait;
  logic        branch_jump_signal;
  logic [31:0] branch_target;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;

  // Stage control
  logic        pc_write_en;
  logic        if_id_hold;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        pipe_freeze;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_busywait, dmem_busywait, branch_jump_signal, branch_target,
           ex_mem_read, ex_rd, id_rs1, id_rs2,
    input  pc_write_en, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_busywait, dmem_busywait, branch_jump_signal, branch_target,
           ex_mem_read, ex_rd, id_rs1, id_rs2,
    output pc_write_en, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Resolves, in priority order: data-memory wait (whole pipe frozen), fetch
// redirect (live branch or one remembered across a freeze / imem wait),
// load-use interlock, and instruction-memory wait (bubble into IF/ID).
// All stage controls are combinational from state and inputs.
//
// Optional build macro HAZARD_PERF_CNT_EN adds the saturating performance
// counters stall_cycles (cycles with pc_write_en=0) and flush_count
// (redirect cycles). Without the macro these ports do not exist.
module pipeline_hazard_ctrl (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [15:0]            flush_count
`endif
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LU_STALL   = 2'd1;
  localparam logic [1:0] MEM_WAIT   = 2'd2;
  localparam logic [1:0] REDIR_PEND = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic        load_use_hit;
  logic        pend_redir;
  logic        redir_any;
  logic [31:0] redir_tgt;

  logic        pc_write_en_c;
  logic        if_id_hold_c;
  logic        if_id_flush_c;
  logic        id_ex_flush_c;
  logic        pipe_freeze_c;
  logic        redirect_valid_c;
  logic [31:0] redirect_pc_c;

  // Hazard detection terms shared by output and next-state logic
  always_comb begin
    load_use_hit = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                   ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
    // A remembered redirect is owed after a freeze that caught a branch, or
    // while fetch has not yet accepted an earlier redirect.
    pend_redir   = (state_q == REDIR_PEND) || ((state_q == MEM_WAIT) && pend_q);
    redir_any    = pend_redir || bus.branch_jump_signal;
    // The remembered branch is older than anything now in EX, so it wins.
    redir_tgt    = pend_redir ? pend_tgt_q : bus.branch_target;
  end

  // Stage control outputs by priority: reset, dmem freeze, redirect, load-use, imem bubble
  always_comb begin
    pc_write_en_c    = 1'b1;
    if_id_hold_c     = 1'b0;
    if_id_flush_c    = 1'b0;
    id_ex_flush_c    = 1'b0;
    pipe_freeze_c    = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = 32'd0;
    if (!reset) begin
      pc_write_en_c  = 1'b0;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
    end else if (bus.dmem_busywait) begin
      pc_write_en_c  = 1'b0;
      if_id_hold_c   = 1'b1;
      pipe_freeze_c  = 1'b1;
    end else if (redir_any) begin
      redirect_valid_c = 1'b1;
      redirect_pc_c    = redir_tgt;
      if_id_flush_c    = 1'b1;
      id_ex_flush_c    = 1'b1;
    end else if ((state_q == RUN) && load_use_hit) begin
      pc_write_en_c  = 1'b0;
      if_id_hold_c   = 1'b1;
      id_ex_flush_c  = 1'b1;
    end else if (bus.imem_busywait) begin
      pc_write_en_c  = 1'b0;
      if_id_flush_c  = 1'b1;
    end
  end

  assign bus.pc_write_en    = pc_write_en_c;
  assign bus.if_id_hold     = if_id_hold_c;
  assign bus.if_id_flush    = if_id_flush_c;
  assign bus.id_ex_flush    = id_ex_flush_c;
  assign bus.pipe_freeze    = pipe_freeze_c;
  assign bus.redirect_valid = redirect_valid_c;
  assign bus.redirect_pc    = redirect_pc_c;

  // Next state and pending-redirect bookkeeping
  always_comb begin
    state_d    = RUN;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (bus.dmem_busywait) begin
      state_d = MEM_WAIT;
      // A later pulse during the same freeze replaces the earlier target.
      if (bus.branch_jump_signal) begin
        pend_d     = 1'b1;
        pend_tgt_d = bus.branch_target;
      end
    end else if (redir_any) begin
      if (bus.imem_busywait) begin
        // Fetch cannot take the new PC yet; keep offering it.
        state_d    = REDIR_PEND;
        pend_d     = 1'b1;
        pend_tgt_d = redir_tgt;
      end else begin
        state_d    = RUN;
        pend_d     = 1'b0;
        pend_tgt_d = 32'd0;
      end
    end else if ((state_q == RUN) && load_use_hit) begin
      state_d = LU_STALL;
    end else begin
      state_d = RUN;
    end
  end

  // Controller state registers; reset discards any owed redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counter increments: stalled-PC cycles and redirect cycles
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write_en_c) stall_cycles_d = sat_inc32(stall_cycles_q);
    if (redirect_valid_c) flush_count_d = sat_inc16(flush_count_q);
  end

  // Counter registers, cleared while in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-003 SHALL have port: imem_busywait  input  1  instruction memory/cache not ready.
REQ-004 SHALL have port: dmem_busywait  input  1  data memory/cache not ready.
REQ-005 SHALL have port: branch_jump_signal  input  1  one-cycle pulse: EX resolved taken branch/jump.
REQ-006 SHALL have port: branch_target  input  32  target PC for branch_jump_signal.
REQ-007 SHALL have ports: ex_mem_read  input  1, and ex_rd  input  5  load in EX and its destination register.
REQ-008 SHALL have ports: id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-009 SHALL have ports: pc_write_en, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze  output  1 each  stage control signals.
REQ-010 SHALL have ports: redirect_valid  output  1, and redirect_pc  output  32  PC redirect to fetch.

Function
REQ-011 SHALL hold 2-bit state in {RUN=0, LU_STALL=1, MEM_WAIT=2, REDIR_PEND=3}, plus a pending-target register (32 bits) and a pending flag.
REQ-012 SHALL drive outputs combinationally from state and inputs, with no output register stage.
REQ-013 Priority, highest first: dmem_busywait > redirect (live or pending) > load-use > imem_busywait > normal flow.
REQ-014 On dmem_busywait=1 in any state: pipe_freeze=1, pc_write_en=0, if_id_hold=1, all flushes 0, redirect_valid=0; next state MEM_WAIT.
REQ-015 On branch_jump_signal=1 while dmem_busywait=1: SHALL latch branch_target and set pending; a later pulse while frozen overwrites the latch.
REQ-016 MEM_WAIT with dmem_busywait=0: if pending, redirect this cycle (REQ-017) and clear pending; else apply normal rules; then go to RUN.
REQ-017 Redirect cycle: redirect_valid=1, redirect_pc=target, pc_write_en=1, if_id_flush=1, id_ex_flush=1; the load-use and imem stalls are ignored in that cycle.
REQ-018 Load-use, in RUN only: ex_mem_read=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2 -> pc_write_en=0, if_id_hold=1, id_ex_flush=1; next state LU_STALL.
REQ-019 LU_STALL SHALL last exactly one cycle with no load-use detection, then return to RUN.
REQ-020 imem_busywait=1 with no higher-priority event: pc_write_en=0, if_id_flush=1 (bubble into IF/ID), downstream flows.
REQ-021 Normal flow: pc_write_en=1, all holds, flushes and freeze 0, redirect_valid=0, redirect_pc=0.
REQ-022 REDIR_PEND: state entered when a redirect coincides with imem_busywait=1; redirect_valid and redirect_pc SHALL stay asserted until imem_busywait=0, then return to RUN.

Reset
REQ-023 While reset=0: state=RUN, pending=0, pending target=0; pc_write_en=0, if_id_flush=1, id_ex_flush=1, if_id_hold=0, pipe_freeze=0, redirect_valid=0, redirect_pc=0.
REQ-024 Reset asserted mid-stall or mid-redirect SHALL discard the pending redirect; the first cycle after release is RUN.

Configuration
REQ-025 Macro HAZARD_PERF_CNT_EN: when defined, the block SHALL add outputs stall_cycles (32-bit) and flush_count (16-bit), both reset to 0 and saturating.
REQ-026 stall_cycles SHALL increment for each cycle with pc_write_en=0 outside reset; flush_count SHALL increment for each redirect cycle.
REQ-027 Without HAZARD_PERF_CNT_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 -> one cycle with pc_write_en=0, if_id_hold=1, id_ex_flush=1; next cycle normal; ex_rd=0 -> no stall.
REQ-029 Branch: branch_jump_signal=1, branch_target=0x100 -> same cycle redirect_valid=1, redirect_pc=0x100, both flushes=1.
REQ-030 Branch during dmem stall: dmem_busywait=1 for 3 cycles, pulse at cycle 1 with target 0x200 -> frozen 3 cycles, redirect to 0x200 on cycle 4.
REQ-031 Branch coinciding with load-use and imem_busywait=1 -> redirect wins; redirect_valid held until imem ready.
REQ-032 Reset low during pending redirect -> all outputs at REQ-023 values; no redirect after release; counters=0 with HAZARD_PERF_CNT_EN.
